// File: rtl/b_maq_operand_feeder.sv
// b_maq_operand_feeder: sequential front end for the cell-state requantizer
// (Ct = f*Ct-1 + i*g).
//
// Accepts one quantized (f, c_prev, i, g) tuple per element over a valid/ready
// handshake. It registers the signed f*(Ct-1) product together with i and g,
// and holds them for the combinational MAQ stage. When that stage consumes the
// operand, the returned saturated byte is written back to the Ct buffer at the
// element index. One VEC_LEN vector is processed per start, and done pulses
// after the last write-back.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start                begin a vector (honoured only when idle)
//   busy, done           busy in RUN/DONE; done is a one-cycle pulse
//   in_valid, in_ready   operand tuple handshake
//   f_q, c_prev_q        forget gate and previous cell state (quantized)
//   i_q, g_q             input gate and candidate (quantized)
//   comb_ctrl            7 while an operand is held, else 0
//   temp_regA/B/C        held operand: f*(Ct-1) product, i_q, g_q
//   out_ready            downstream consumes the held operand this cycle
//   B_sat_MAQ            saturated result from the MAQ stage
//   c_wr_en/addr/data    Ct buffer write port
module b_maq_operand_feeder #(
  parameter logic [7:0]  ZERO_STATE       = 8'd128,
  parameter logic [7:0]  OUT_ZERO_SIGMOID = 8'd0,
  parameter int unsigned VEC_LEN          = 64,
  parameter int unsigned CNT_W            = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       f_q,
  input  logic [7:0]       c_prev_q,
  input  logic [7:0]       i_q,
  input  logic [7:0]       g_q,
  output logic [4:0]       comb_ctrl,
  output logic [16:0]      temp_regA,
  output logic [7:0]       temp_regB,
  output logic [7:0]       temp_regC,
  input  logic             out_ready,
  input  logic [7:0]       B_sat_MAQ,
  output logic             c_wr_en,
  output logic [CNT_W-1:0] c_wr_addr,
  output logic [7:0]       c_wr_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] VecLen = CNT_W'(VEC_LEN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, wr_cnt_q;
  logic             hold_valid_q;
  logic             accept, retire;

  // Zero-point-removed operands fit in 9 signed bits. They are carried in 18
  // bits so that the product needs no implicit extension. The low 17 bits
  // hold the full product range for 8-bit zero points.
  logic signed [17:0] f_off, c_off, prod;

  assign f_off = $signed({10'd0, f_q}) - $signed({10'd0, OUT_ZERO_SIGMOID});
  assign c_off = $signed({10'd0, c_prev_q}) - $signed({10'd0, ZERO_STATE});
  assign prod  = f_off * c_off;

  // A retiring operand frees the holding slot in the same cycle, which allows
  // one element per cycle when streaming.
  assign in_ready  = (state_q == StRun) && (acc_cnt_q < VecLen) && (!hold_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire    = hold_valid_q && out_ready;
  assign comb_ctrl = hold_valid_q ? 5'd7 : 5'd0;
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign done      = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      // wr_cnt_q reaches VecLen on the final retire edge, so DONE follows
      // one cycle after the last write strobe.
      StRun:   if (wr_cnt_q == VecLen) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      hold_valid_q <= 1'b0;
      temp_regA    <= '0;
      temp_regB    <= '0;
      temp_regC    <= '0;
      c_wr_en      <= 1'b0;
      c_wr_addr    <= '0;
      c_wr_data    <= '0;
    end else begin
      state_q <= state_d;
      c_wr_en <= 1'b0;

      if ((state_q == StIdle) && start) begin
        acc_cnt_q    <= '0;
        wr_cnt_q     <= '0;
        hold_valid_q <= 1'b0;
      end

      if (accept) begin
        temp_regA    <= prod[16:0];
        temp_regB    <= i_q;
        temp_regC    <= g_q;
        acc_cnt_q    <= acc_cnt_q + CNT_W'(1);
        hold_valid_q <= 1'b1;
      end else if (retire) begin
        // The operand registers keep their values; only the valid flag drops.
        hold_valid_q <= 1'b0;
      end

      if (retire) begin
        c_wr_en   <= 1'b1;
        c_wr_addr <= wr_cnt_q;
        c_wr_data <= B_sat_MAQ;
        wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_b_maq_operand_feeder.sv
module tb_b_maq_operand_feeder;

  localparam int VEC   = 4;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rstn, start, in_valid, out_ready;
  logic             busy, done, in_ready, c_wr_en;
  logic [7:0]       f_q, c_prev_q, i_q, g_q, B_sat_MAQ;
  logic [4:0]       comb_ctrl;
  logic [16:0]      temp_regA;
  logic [7:0]       temp_regB, temp_regC, c_wr_data;
  logic [CNT_W-1:0] c_wr_addr;

  b_maq_operand_feeder #(
    .ZERO_STATE      (8'd128),
    .OUT_ZERO_SIGMOID(8'd0),
    .VEC_LEN         (VEC),
    .CNT_W           (CNT_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .f_q      (f_q),
    .c_prev_q (c_prev_q),
    .i_q      (i_q),
    .g_q      (g_q),
    .comb_ctrl(comb_ctrl),
    .temp_regA(temp_regA),
    .temp_regB(temp_regB),
    .temp_regC(temp_regC),
    .out_ready(out_ready),
    .B_sat_MAQ(B_sat_MAQ),
    .c_wr_en  (c_wr_en),
    .c_wr_addr(c_wr_addr),
    .c_wr_data(c_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected write-backs {addr, data}, pushed when a retire is driven.
  logic [CNT_W+7:0] wq[$];

  // Bench view of the handshake: accepted, written, operand held.
  int m_acc, m_wr;
  bit m_hold;

  function automatic logic [16:0] exp_prod(input logic [7:0] f, input logic [7:0] c);
    int p;
    p = (int'(f) - 0) * (int'(c) - 128);
    return p[16:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_acc = 0; m_wr = 0; m_hold = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
    if (busy !== 1'b1) n_bad++;
  endtask

  // Stream with in_valid and out_ready held high until stop_wr writes have
  // occurred. If the whole vector completes, check the done pulse timing.
  task automatic stream(input int stop_wr, input bit start_noise);
    int guard;
    guard = 0;
    while (m_wr < stop_wr && guard < 20) begin
      logic [7:0] f, c, i, g, d;
      bit acc, ret;
      logic [CNT_W+7:0] e;
      f = 8'($urandom); c = 8'($urandom); i = 8'($urandom); g = 8'($urandom);
      d = 8'($urandom);
      f_q = f; c_prev_q = c; i_q = i; g_q = g; B_sat_MAQ = d;
      in_valid = 1'b1; out_ready = 1'b1; start = start_noise;
      acc = (m_acc < VEC);
      ret = m_hold;
      #1;
      n_cmp++;
      if (in_ready !== acc) begin
        $display("FAIL stream_in_ready: acc=%0d got %b want %b", m_acc, in_ready, acc);
        n_bad++;
      end
      if (ret) begin
        wq.push_back({CNT_W'(m_wr), d});
        m_wr++;
      end
      tick();
      n_cmp++;
      if (c_wr_en !== ret) begin
        $display("FAIL stream_wr_en: got %b want %b", c_wr_en, ret);
        n_bad++;
      end else if (ret) begin
        e = wq.pop_front();
        n_cmp++;
        if ({c_wr_addr, c_wr_data} !== e) begin
          $display("FAIL stream_write: got addr %0d data %h want addr %0d data %h",
                   c_wr_addr, c_wr_data, e[CNT_W+7:8], e[7:0]);
          n_bad++;
        end
      end
      if (acc) begin
        m_acc++;
        m_hold = 1'b1;
        n_cmp++;
        if ({temp_regA, temp_regB, temp_regC} !== {exp_prod(f, c), i, g}) begin
          $display("FAIL stream_operand: got %h/%h/%h want %h/%h/%h", temp_regA, temp_regB,
                   temp_regC, exp_prod(f, c), i, g);
          n_bad++;
        end
      end else begin
        m_hold = 1'b0;
      end
      n_cmp++;
      if (comb_ctrl !== (m_hold ? 5'd7 : 5'd0)) begin
        $display("FAIL stream_comb_ctrl: got %0d hold %b", comb_ctrl, m_hold);
        n_bad++;
      end
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    n_cmp++;
    if (guard >= 20) begin
      $display("FAIL stream_timeout: wrote %0d want %0d", m_wr, stop_wr);
      n_bad++;
    end
    if (stop_wr == VEC) begin
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
        $display("FAIL done_early: got %b want 0", done);
        n_bad++;
      end
      tick();
      n_cmp++;
      if ({done, busy} !== 2'b11) begin
        $display("FAIL done_pulse: done/busy got %b want 11", {done, busy});
        n_bad++;
      end
      tick();
      n_cmp++;
      if ({done, busy, c_wr_en} !== 3'b000) begin
        $display("FAIL done_end: done/busy/wr got %b want 000", {done, busy, c_wr_en});
        n_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      f_q = 8'($urandom); c_prev_q = 8'($urandom); i_q = 8'($urandom); g_q = 8'($urandom);
      B_sat_MAQ = 8'($urandom);
      tick();
    end
    #1;
    n_cmp++;
    if ({busy, done, in_ready, comb_ctrl, temp_regA, temp_regB, temp_regC, c_wr_en, c_wr_addr,
         c_wr_data} !== '0) begin
      $display("FAIL reset_outputs: busy %b done %b rdy %b ctrl %0d A %h wr %b addr %0d data %h",
               busy, done, in_ready, comb_ctrl, temp_regA, c_wr_en, c_wr_addr, c_wr_data);
      n_bad++;
    end
    rstn = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    do_start();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_start_ready: got %b want 1", in_ready);
      n_bad++;
    end
  endtask

  task automatic test_arith();
    logic [CNT_W+7:0] e;
    f_q = 8'd255; c_prev_q = 8'd255; i_q = 8'd10; g_q = 8'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    m_acc = 1; m_hold = 1'b1;
    #1;
    n_cmp++;
    if ({temp_regA, temp_regB, temp_regC, comb_ctrl} !== {17'h07E81, 8'd10, 8'd20, 5'd7}) begin
      $display("FAIL arith_max: got A %h B %0d C %0d ctrl %0d want 07e81/10/20/7",
               temp_regA, temp_regB, temp_regC, comb_ctrl);
      n_bad++;
    end
    f_q = 8'd128; c_prev_q = 8'd0; i_q = 8'd3; g_q = 8'd4;
    in_valid = 1'b1; out_ready = 1'b1; B_sat_MAQ = 8'h11;
    wq.push_back({CNT_W'(0), 8'h11});
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL arith_ready_on_retire: got %b want 1", in_ready);
      n_bad++;
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    m_acc = 2; m_wr = 1;
    #1;
    n_cmp++;
    if ({temp_regA, temp_regB, temp_regC, comb_ctrl} !== {17'h1C000, 8'd3, 8'd4, 5'd7}) begin
      $display("FAIL arith_neg: got A %h B %0d C %0d ctrl %0d want 1c000/3/4/7",
               temp_regA, temp_regB, temp_regC, comb_ctrl);
      n_bad++;
    end
    n_cmp++;
    if (c_wr_en !== 1'b1) begin
      $display("FAIL arith_wr_en: got %b want 1", c_wr_en);
      n_bad++;
    end else begin
      e = wq.pop_front();
      n_cmp++;
      if ({c_wr_addr, c_wr_data} !== e) begin
        $display("FAIL arith_write: got %0d/%h want %0d/%h", c_wr_addr, c_wr_data,
                 e[CNT_W+7:8], e[7:0]);
        n_bad++;
      end
    end
    stream(VEC, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [CNT_W+7:0] e;
    do_start();
    f_q = 8'd7; c_prev_q = 8'd200; i_q = 8'd1; g_q = 8'd2; in_valid = 1'b1;
    tick();
    m_acc = 1; m_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f_q = 8'($urandom); c_prev_q = 8'($urandom); in_valid = 1'b1; out_ready = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, c_wr_en, temp_regA} !== {1'b0, 1'b0, exp_prod(8'd7, 8'd200)}) begin
        $display("FAIL bp_hold: rdy %b wr %b A %h want 0 0 %h", in_ready, c_wr_en, temp_regA,
                 exp_prod(8'd7, 8'd200));
        n_bad++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; B_sat_MAQ = 8'hA5;
    wq.push_back({CNT_W'(0), 8'hA5});
    tick();
    out_ready = 1'b0;
    m_wr = 1; m_hold = 1'b0;
    #1;
    n_cmp++;
    if ({c_wr_en, comb_ctrl, temp_regA} !== {1'b1, 5'd0, exp_prod(8'd7, 8'd200)}) begin
      $display("FAIL bp_retire: wr %b ctrl %0d A %h want 1 0 %h", c_wr_en, comb_ctrl, temp_regA,
               exp_prod(8'd7, 8'd200));
      n_bad++;
    end
    if (wq.size() != 0) begin
      e = wq.pop_front();
      n_cmp++;
      if ({c_wr_addr, c_wr_data} !== e) begin
        $display("FAIL bp_write: got %0d/%h want %0d/%h", c_wr_addr, c_wr_data,
                 e[CNT_W+7:8], e[7:0]);
        n_bad++;
      end
    end
    stream(VEC, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_start();
    stream(VEC, 1'b0);
  endtask

  task automatic test_start_in_run();
    do_start();
    stream(VEC, 1'b1);
  endtask

  task automatic test_reset_mid();
    int ndone;
    do_start();
    stream(2, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, in_ready, comb_ctrl, temp_regA, temp_regB, temp_regC, c_wr_en, c_wr_addr,
         c_wr_data} !== '0) begin
      $display("FAIL mid_reset_outputs: busy %b done %b ctrl %0d wr %b addr %0d", busy, done,
               comb_ctrl, c_wr_en, c_wr_addr);
      n_bad++;
    end
    ndone = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done === 1'b1 || c_wr_en === 1'b1) ndone++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (ndone != 0) begin
      $display("FAIL mid_reset_quiet: %0d done/write cycles after reset, want 0", ndone);
      n_bad++;
    end
    do_start();
    stream(VEC, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    f_q = '0; c_prev_q = '0; i_q = '0; g_q = '0; B_sat_MAQ = '0;
    m_acc = 0; m_wr = 0; m_hold = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid();
    n_cmp++;
    if (wq.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d writes never seen", wq.size());
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
